alu_seq: RTL

- Parametrised, handshaked successor to the single-cycle datapath ALU for the KGP RISC core.
- Keeps the 5-bit ALU_C opcode space and the 3-bit flag output.
- Adds a valid/ready handshake on input and output, a registered result, and iterative multi-cycle shifts at one bit per cycle.
- Adds an optional iterative shift-add multiplier.
- Sits between the decode/register-read stage and writeback; the pipeline stalls on in_ready/out_valid.

---
 rtl/alu_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, one-bit-per-cycle shifts.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier on opcode 11000.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALU_C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [2:0]       flags,
  output logic             busy
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_AND  = 5'b00001;
  localparam logic [4:0] OP_XOR  = 5'b00010;
  localparam logic [4:0] OP_COMP = 5'b10100;
  localparam logic [4:0] OP_SLL  = 5'b00011;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b01111;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [4:0] OP_MUL  = 5'b11000;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [4:0]       op;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   first_shift;
  logic [WIDTH:0]   next_shift;
  logic [WIDTH:0]   single;
  logic [WIDTH-1:0] step_val;
  logic             step_carry;

  function automatic logic is_shift(input logic [4:0] o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
  endfunction

  // One shift position; returns {bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift_step(input logic [4:0] o, input logic [WIDTH-1:0] v);
    case (o)
      OP_SLL:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_SRL:  return {v[0], 1'b0, v[WIDTH-1:1]};
      default: return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  // Ops finishing at the accept edge; shift opcodes only reach here with shamt 0.
  function automatic logic [WIDTH:0] single_op(input logic [4:0] o, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (o)
      OP_ADD:                 return {1'b0, a} + {1'b0, b};
      OP_AND:                 return {1'b0, a & b};
      OP_XOR:                 return {1'b0, a ^ b};
      OP_COMP:                return {1'b0, ~b + WIDTH'(1)};
      OP_SLL, OP_SRL, OP_SRA: return {1'b0, a};
      default:                return '0;
    endcase
  endfunction

  function automatic logic [2:0] mk_flags(input logic c, input logic [WIDTH-1:0] r);
    return {c, r == '0, r[WIDTH-1]};
  endfunction

  assign shamt       = B[SHW-1:0];
  assign first_shift = shift_step(ALU_C, A);
  assign next_shift  = shift_step(op, acc);
  assign single      = single_op(ALU_C, A, B);

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mhi;
  logic [WIDTH:0]   mul_first;
  logic [WIDTH:0]   mul_sum;

  // Right-shifting product register {mhi, acc}; acc starts as the multiplier.
  assign mul_first = B[0] ? {1'b0, A} : '0;
  assign mul_sum   = {1'b0, mhi} + (acc[0] ? {1'b0, mcand} : '0);

  always_comb begin
    step_val   = next_shift[WIDTH-1:0];
    step_carry = next_shift[WIDTH];
    if (op == OP_MUL) begin
      step_val   = {mul_sum[0], acc[WIDTH-1:1]};
      step_carry = |mul_sum[WIDTH:1];
    end
  end
`else
  assign step_val   = next_shift[WIDTH-1:0];
  assign step_carry = next_shift[WIDTH];
`endif

  always_ff @(posedge clka) begin
    if (rst) begin
      state     <= IDLE;
      op        <= '0;
      acc       <= '0;
      cnt       <= '0;
      res       <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand     <= '0;
      mhi       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op       <= ALU_C;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            // The accept edge already performs the first iteration.
            if (is_shift(ALU_C) && shamt > SHW'(1)) begin
              acc   <= first_shift[WIDTH-1:0];
              cnt   <= shamt - SHW'(1);
              state <= BUSY;
            end else if (is_shift(ALU_C) && shamt == SHW'(1)) begin
              res       <= first_shift[WIDTH-1:0];
              flags     <= mk_flags(first_shift[WIDTH], first_shift[WIDTH-1:0]);
              out_valid <= 1'b1;
              state     <= DONE;
`ifdef ALU_SEQ_MUL_EN
            end else if (ALU_C == OP_MUL) begin
              mcand <= A;
              mhi   <= mul_first[WIDTH:1];
              acc   <= {mul_first[0], B[WIDTH-1:1]};
              cnt   <= SHW'(WIDTH - 1);
              state <= BUSY;
`endif
            end else begin
              res       <= single[WIDTH-1:0];
              flags     <= mk_flags(single[WIDTH], single[WIDTH-1:0]);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          acc <= step_val;
          cnt <= cnt - SHW'(1);
`ifdef ALU_SEQ_MUL_EN
          mhi <= mul_sum[WIDTH:1];
`endif
          if (cnt == SHW'(1)) begin
            res       <= step_val;
            flags     <= mk_flags(step_carry, step_val);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
